// File: rtl/fetch_unit_pkg.sv
// Shared constants, next-PC select encodings and the fetch-address legality check
// for the fetch stage.
package fetch_unit_pkg;

   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] IM_BASE    = 32'h0000_3000;
   localparam int unsigned IM_WORDS   = 4096;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   // Limit is computed in 33 bits so a window ending at 2^32 does not wrap to zero.
   function automatic logic fetch_adel(input logic [31:0] pc, input logic [31:0] base,
                                       input int unsigned words);
      logic [32:0] limit;
      limit = {1'b0, base} + {words[30:0], 2'b00};
      return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
   endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC selection; branch and jump targets are relative to the
// instruction in ID, so the delay slot is fetched normally.
module fetch_unit_npc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] id_pc,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc
);

   logic [31:0] pc_plus4;
   logic [31:0] id_plus4;
   logic [31:0] br_offset;

   assign pc_plus4  = pc + 32'd4;
   assign id_plus4  = id_pc + 32'd4;
   assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      unique case (npc_sel)
         NPC_SEQ: next_pc = pc_plus4;
         NPC_BR:  next_pc = br_taken ? (id_plus4 + br_offset) : pc_plus4;
         NPC_J:   next_pc = {id_plus4[31:28], imm26, 2'b00};
         NPC_JR:  next_pc = jr_target;
         default: next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, illegal-address
// check and a count of instructions delivered to ID.
module fetch_unit #(
   parameter logic [31:0] PC_RESET   = fetch_unit_pkg::PC_RESET,
   parameter logic [31:0] EXC_VECTOR = fetch_unit_pkg::EXC_VECTOR,
   parameter logic [31:0] IM_BASE    = fetch_unit_pkg::IM_BASE,
   parameter int unsigned IM_WORDS   = fetch_unit_pkg::IM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] jr_target,
   output logic [31:0] im_addr,
   input  logic [31:0] im_data,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        id_exc_adel,
   output logic [31:0] fetch_count
);

   import fetch_unit_pkg::*;

   logic [31:0] pc_q;
   logic [31:0] next_pc;
   logic        adel;
   logic [31:0] id_pc_q;
   logic [31:0] id_instr_q;
   logic        id_valid_q;
   logic        id_adel_q;
   logic [31:0] count_q;

   fetch_unit_npc npc (
      .pc        (pc_q),
      .id_pc     (id_pc_q),
      .npc_sel   (npc_sel),
      .br_taken  (br_taken),
      .imm16     (imm16),
      .imm26     (imm26),
      .jr_target (jr_target),
      .next_pc   (next_pc)
   );

   assign adel = fetch_adel(pc_q, IM_BASE, IM_WORDS);

   // A stalled edge drops any redirect; ID re-presents it on the next unstalled edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= PC_RESET;
         id_pc_q    <= '0;
         id_instr_q <= '0;
         id_valid_q <= 1'b0;
         id_adel_q  <= 1'b0;
         count_q    <= '0;
      end else if (flush) begin
         pc_q       <= EXC_VECTOR;
         id_pc_q    <= '0;
         id_instr_q <= '0;
         id_valid_q <= 1'b0;
         id_adel_q  <= 1'b0;
      end else if (!stall) begin
         pc_q       <= next_pc;
         id_pc_q    <= pc_q;
         id_instr_q <= adel ? 32'h0 : im_data;
         id_valid_q <= 1'b1;
         id_adel_q  <= adel;
         count_q    <= count_q + 32'd1;
      end
   end

   assign im_addr     = pc_q;
   assign id_pc       = id_pc_q;
   assign id_instr    = id_instr_q;
   assign id_valid    = id_valid_q;
   assign id_exc_adel = id_adel_q;
   assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters, one per line:
- PC_RESET, 32'h0000_3000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on flush.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words.
REQ-002 Ports, one per line:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID register.
- flush  in  1  clear IF/ID register and redirect PC to EXC_VECTOR.
- npc_sel  in  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 jr.
- br_taken  in  1  branch condition; meaningful only when npc_sel=01.
- imm16  in  16  branch offset, in words.
- imm26  in  26  jump index.
- jr_target  in  32  register-jump target.
- im_addr  out  32  fetch address driven to instruction memory.
- im_data  in  32  instruction word returned combinationally by memory.
- id_pc  out  32  PC of the instruction held in IF/ID.
- id_instr  out  32  instruction held in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_exc_adel  out  1  instruction in IF/ID had an illegal fetch address.
- fetch_count  out  32  number of valid instructions loaded into IF/ID.

Function
REQ-003 The PC register SHALL drive im_addr directly, with no combinational logic on the path, so the fetch result is available in the same cycle.
REQ-004 Next-PC SHALL be computed from id_pc, because branches resolve in ID and the delay slot is architectural.
- seq: pc+4.
- branch: if br_taken, id_pc+4+(sext(imm16)<<2); otherwise pc+4.
- jump: {id_pc+4 [31:28], imm26, 2'b00}.
- jr: jr_target.
REQ-005 Adder overflow SHALL wrap modulo 2^32 without any flag.
REQ-006 Update priority on each rising edge:
- flush: PC<=EXC_VECTOR; IF/ID cleared (id_instr=0, id_valid=0, id_exc_adel=0, id_pc=0).
- else stall: PC and IF/ID hold; fetch_count holds.
- else: PC<=next-PC; IF/ID<={pc, instr, 1, adel}.
REQ-007 adel SHALL assert combinationally when pc[1:0]!=0, pc<IM_BASE, or pc>=IM_BASE+4*IM_WORDS.
- When adel is set, the IF/ID register SHALL latch instr=32'h0 instead of im_data.
REQ-008 A redirect (npc_sel!=00) that coincides with stall SHALL be dropped; it is re-presented while the ID instruction is held.
REQ-009 No instruction SHALL be squashed on a branch or jump; the delay-slot instruction in IF SHALL be loaded normally.
REQ-010 fetch_count SHALL increment by 1 on each non-flush, non-stall edge, wrap from 32'hFFFF_FFFF to 0, and count adel instructions.
REQ-011 If flush and stall assert together, flush SHALL win.

Reset
REQ-012 While reset=0, asynchronously and independent of clk:
- PC=PC_RESET, so im_addr=32'h0000_3000.
- id_pc=0, id_instr=0, id_valid=0, id_exc_adel=0, fetch_count=0.
REQ-013 Reset asserted mid-operation SHALL override stall and flush immediately.
REQ-014 The first rising edge after reset deasserts SHALL load the instruction at 0x3000 into IF/ID.

Structure
REQ-015 A shared package SHALL hold PC_RESET, EXC_VECTOR, IM_BASE, IM_WORDS and the npc_sel encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR).
REQ-016 Next-PC calculation SHALL live in one combinational sub-module, npc.
- fetch_unit SHALL hold the PC register, IF/ID register, adel check and counter.

Verification
REQ-017 Reset, release, 3 clean edges -> id_pc 0x3000, 0x3004, 0x3008 in turn; fetch_count=3; id_valid=1.
REQ-018 id_pc=0x3010, npc_sel=01, br_taken=1, imm16=16'hFFFC -> PC becomes 0x3004; the delay slot at the old PC+4 still enters IF/ID.
REQ-019 npc_sel=11 with jr_target=0x3002 -> next IF/ID has id_exc_adel=1, id_instr=0; a repeat with jr_target=0x7000 gives the same result.
REQ-020 stall=1 held for 2 cycles while npc_sel=10 -> PC and IF/ID unchanged and fetch_count unchanged; after stall drops, the jump takes effect.
REQ-021 flush=1 and stall=1 together -> PC=0x4180, id_valid=0, id_instr=0.
REQ-022 reset pulsed low between clock edges -> all outputs reach their reset values before the next edge; im_addr=0x3000.
